// File: rtl/conv_stream_sink_checker.sv
// Receiver/checker for the conv_8_4 y stream: accepts words with optional LFSR
// throttling, compares them against a preloaded expected RAM, and reports errors.
module conv_stream_sink_checker #(
  parameter int          DATA_W    = 18,
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter int          TIMEOUT   = 10000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data_in_y,
  input  logic              s_valid_y,
  output logic              s_ready_y,
  input  logic              exp_wr_en,
  input  logic [AW-1:0]     exp_wr_addr,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic [AW:0]       num_expected,
  input  logic              throttle_en,
  input  logic              start,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       err_count,
  output logic [AW-1:0]     first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic              timeout,
  output logic              stray_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [AW:0]       idx;
  logic [AW:0]       num_q;
  logic [WDW-1:0]    watchdog;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic              hs;
  logic              mismatch;
  logic [DATA_W-1:0] exp_rd;
  logic [DATA_W-1:0] exp_mem [DEPTH];

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign s_ready_y = (state == RUN) && (!throttle_en || lfsr[0]);
  assign hs        = s_valid_y && s_ready_y;
  assign exp_rd    = exp_mem[idx[AW-1:0]];
  assign mismatch  = hs && (s_data_in_y != exp_rd);

  // A start in the same cycle as a write wins; the write is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && exp_wr_en && !start)
      exp_mem[exp_wr_addr] <= exp_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
      stray_valid    <= 1'b0;
      idx            <= '0;
      num_q          <= '0;
      watchdog       <= '0;
      lfsr           <= LFSR_SEED;
    end else if (start && state != RUN) begin
      idx            <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
      stray_valid    <= 1'b0;
      watchdog       <= '0;
      lfsr           <= LFSR_SEED;
      num_q          <= num_expected;
      // An empty run completes immediately and trivially passes.
      if (num_expected == '0) begin
        state <= DONE;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else begin
        state <= RUN;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          lfsr <= {lfsr[14:0], lfsr_fb};
          if (hs) begin
            idx      <= idx + 1'b1;
            watchdog <= '0;
            if (mismatch) begin
              if (err_count != '1)
                err_count <= err_count + 1'b1;
              if (err_count == '0) begin
                first_err_idx  <= idx[AW-1:0];
                first_err_data <= s_data_in_y;
              end
            end
            if (idx == num_q - 1'b1) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end
          end else if (watchdog == WDW'(TIMEOUT - 1)) begin
            state   <= ABORT;
            timeout <= 1'b1;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        DONE: begin
          if (s_valid_y) begin
            stray_valid <= 1'b1;
            pass        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_sink_checker.sv
// Directed self-checking bench for conv_stream_sink_checker (TIMEOUT shortened to 50).
module tb_conv_stream_sink_checker;

  localparam int DATA_W = 18;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] s_data_in_y;
  logic              s_valid_y;
  logic              s_ready_y;
  logic              exp_wr_en;
  logic [AW-1:0]     exp_wr_addr;
  logic [DATA_W-1:0] exp_wr_data;
  logic [AW:0]       num_expected;
  logic              throttle_en;
  logic              start;
  logic              done;
  logic              pass;
  logic [AW:0]       err_count;
  logic [AW-1:0]     first_err_idx;
  logic [DATA_W-1:0] first_err_data;
  logic              timeout;
  logic              stray_valid;

  int passed = 0;
  int total  = 0;
  int vec [10] = '{-2800, 3600, 400, 1600, 2800, 400, 6000, -2000, 2200, 600};
  int hs_cnt;
  int cyc;

  conv_stream_sink_checker #(
    .DATA_W   (DATA_W),
    .DEPTH    (16),
    .AW       (AW),
    .TIMEOUT  (50),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_data_in_y   (s_data_in_y),
    .s_valid_y     (s_valid_y),
    .s_ready_y     (s_ready_y),
    .exp_wr_en     (exp_wr_en),
    .exp_wr_addr   (exp_wr_addr),
    .exp_wr_data   (exp_wr_data),
    .num_expected  (num_expected),
    .throttle_en   (throttle_en),
    .start         (start),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_data(first_err_data),
    .timeout       (timeout),
    .stray_valid   (stray_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Streams words 0..nsend-1 with valid held high, advancing only on accepted words.
  task automatic do_run(input bit thr, input bit corrupt, input int nsend,
                        output int hs_o, output int cyc_o);
    logic [15:0] lm;
    int          k;
    int          w;
    bit          took;
    num_expected = 5'd10;
    throttle_en  = thr;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk("done_low_in_run", done, 0);
    lm    = 16'hACE1;
    k     = 0;
    hs_o  = 0;
    cyc_o = 0;
    while (k < nsend && cyc_o < 500) begin
      w = vec[k];
      if (corrupt && k == 3) w = 1601;
      if (corrupt && k == 7) w = 0;
      s_valid_y   = 1'b1;
      s_data_in_y = 18'(w);
      #1;
      chk("ready_pattern", s_ready_y, thr ? lm[0] : 1'b1);
      took = s_ready_y;
      tick();
      cyc_o++;
      lm = {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
      if (took) begin
        k++;
        hs_o++;
      end
    end
    if (k < nsend) chk("run_budget", k, nsend);
    s_valid_y   = 1'b0;
    s_data_in_y = 'x;
  endtask

  initial begin
    reset        = 1'b1;
    s_data_in_y  = '0;
    s_valid_y    = 1'b0;
    exp_wr_en    = 1'b0;
    exp_wr_addr  = '0;
    exp_wr_data  = '0;
    num_expected = '0;
    throttle_en  = 1'b0;
    start        = 1'b0;
    repeat (3) tick();
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ready", s_ready_y, 0);
    chk("rst_err", err_count, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      exp_wr_en   = 1'b1;
      exp_wr_addr = 4'(i);
      exp_wr_data = 18'(vec[i]);
      tick();
    end
    exp_wr_en = 1'b0;

    // Clean, unthrottled: one accept per cycle
    do_run(1'b0, 1'b0, 10, hs_cnt, cyc);
    chk("t1_accepts", hs_cnt, 10);
    chk("t1_cycles", cyc, 10);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_ready_off", s_ready_y, 0);
    tick();
    chk("t1_no_stray", stray_valid, 0);

    // Clean, LFSR-throttled
    do_run(1'b1, 1'b0, 10, hs_cnt, cyc);
    chk("t2_accepts", hs_cnt, 10);
    chk("t2_stalled", cyc > 10, 1);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 1);
    chk("t2_err", err_count, 0);

    // Two corrupted words
    do_run(1'b0, 1'b1, 10, hs_cnt, cyc);
    chk("t3_done", done, 1);
    chk("t3_err", err_count, 2);
    chk("t3_first_idx", first_err_idx, 3);
    chk("t3_first_data", $signed(first_err_data), 1601);
    chk("t3_pass", pass, 0);

    // Watchdog: stop after 4 words; abort on the 50th edge after the 4th accept
    do_run(1'b0, 1'b0, 4, hs_cnt, cyc);
    repeat (49) tick();
    chk("t4_not_yet_done", done, 0);
    chk("t4_not_yet_timeout", timeout, 0);
    tick();
    chk("t4_timeout", timeout, 1);
    chk("t4_done", done, 1);
    chk("t4_pass", pass, 0);
    chk("t4_ready_off", s_ready_y, 0);

    // Stray valid after a clean completion
    do_run(1'b0, 1'b0, 10, hs_cnt, cyc);
    chk("t5_pass_before", pass, 1);
    s_valid_y   = 1'b1;
    s_data_in_y = 18'd5;
    #1;
    chk("t5_ready_off", s_ready_y, 0);
    tick();
    s_valid_y = 1'b0;
    chk("t5_stray", stray_valid, 1);
    chk("t5_pass", pass, 0);
    chk("t5_done", done, 1);
    chk("t5_ready_still_off", s_ready_y, 0);

    // Reset mid-run at idx 5, then an empty run
    do_run(1'b0, 1'b1, 5, hs_cnt, cyc);
    chk("t6_err_before_reset", err_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_done", done, 0);
    chk("t6_rst_pass", pass, 0);
    chk("t6_rst_ready", s_ready_y, 0);
    chk("t6_rst_err", err_count, 0);
    chk("t6_rst_fidx", first_err_idx, 0);
    chk("t6_rst_fdata", first_err_data, 0);
    chk("t6_rst_timeout", timeout, 0);
    chk("t6_rst_stray", stray_valid, 0);
    num_expected = '0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_empty_done", done, 1);
    chk("t6_empty_pass", pass, 1);
    chk("t6_empty_ready", s_ready_y, 0);
    chk("t6_empty_err", err_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
